slc3_mem_ctrl: RTL and testbench

Sequenced SRAM and memory-mapped I/O controller between the SLC-3 datapath (MAR/MDR side) and the external 1Mx16 SRAM. It accepts one word-wide read or write request at a time and drives the SRAM strobes with a parameterised number of wait cycles. It owns the bidirectional data bus. It also decodes address 0xFFFF as an I/O port: reads return the switches, writes update the hex display register.

---
 rtl/slc3_mem_pkg.sv | 61 ++++++
 rtl/slc3_mem_if.sv | 32 +++
 rtl/slc3_mem_ctrl_sram_tristate.sv | 37 +++
 rtl/slc3_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_slc3_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// slc3_mem_pkg
// Shared types and constants for the SLC-3 SRAM / memory-mapped I/O controller.
//   mem_state_t     controller FSM states (legacy 3-bit encoding kept explicit)
//   sram_strobe_t   the five active-low SRAM strobes as one packed bundle
//   strobes_for()   strobe levels required in a given state
//   drives_bus()    whether the controller owns the data bus in a given state
// -----------------------------------------------------------------------------
package slc3_mem_pkg;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int          SRAM_ADDR_W     = 20;

    // Legacy encodings, kept as plain constants so older tooling and
    // waveform decoders that match on raw state values still line up.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_STROBE = 3'd1;
    localparam logic [2:0] ST_WR_SETUP  = 3'd2;
    localparam logic [2:0] ST_WR_STROBE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD   = 3'd4;
    localparam logic [2:0] ST_IO        = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        RD_STROBE = ST_RD_STROBE,
        WR_SETUP  = ST_WR_SETUP,
        WR_STROBE = ST_WR_STROBE,
        WR_HOLD   = ST_WR_HOLD,
        IO        = ST_IO,
        DONE      = ST_DONE
    } mem_state_t;

    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
    } sram_strobe_t;

    localparam sram_strobe_t STROBE_IDLE = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1};

    function automatic sram_strobe_t strobes_for(input mem_state_t s);
        sram_strobe_t st;
        st = STROBE_IDLE;
        case (s)
            RD_STROBE: st = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b0, we: 1'b1};
            WR_SETUP:  st = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b1, we: 1'b1};
            WR_STROBE: st = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b1, we: 1'b0};
            WR_HOLD:   st = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: 1'b1, we: 1'b1};
            default:   st = STROBE_IDLE;
        endcase
        return st;
    endfunction

    function automatic logic drives_bus(input mem_state_t s);
        return (s == WR_SETUP) || (s == WR_STROBE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/slc3_mem_if.sv
// -----------------------------------------------------------------------------
// slc3_mem_if
// Request/response bus between the SLC-3 datapath (MAR/MDR side) and the
// memory controller.
//   req    request strobe, sampled by the controller only when idle
//   we     1 = write, 0 = read, sampled with req
//   addr   word address (MAR)
//   wdata  write data (MDR)
//   rdata  registered read data, held until the next read completes
//   ready  one-cycle completion pulse
//   busy   controller is in the middle of an access
// Modports: master = datapath, slave = controller.
// -----------------------------------------------------------------------------
interface slc3_mem_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy
    );
endinterface

// File: rtl/slc3_mem_ctrl_sram_tristate.sv
// -----------------------------------------------------------------------------
// sram_tristate
// Owns the bidirectional SRAM data bus so the controller FSM never touches
// the inout directly. Output enable and output data are registered; the
// input path is combinational so the controller can capture read data on
// the same edge that ends the read strobe.
//   Clk, Reset  clock, synchronous active-low reset
//   oe_d        next-cycle drive enable
//   dout_d      next-cycle drive value
//   din         current value seen on the bus
//   Data        SRAM data bus (inout)
// -----------------------------------------------------------------------------
module sram_tristate (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        oe_d,
    input  logic [15:0] dout_d,
    output logic [15:0] din,
    inout  wire  [15:0] Data
);
    logic        oe_q;
    logic [15:0] dout_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            oe_q   <= 1'b0;
            dout_q <= 16'h0000;
        end else begin
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign Data = oe_q ? dout_q : 16'hzzzz;
    assign din  = Data;

endmodule

// File: rtl/slc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// slc3_mem_ctrl
// Sequenced controller between the SLC-3 datapath and an external 1Mx16
// SRAM. One read or write at a time; the OE/WE strobe is held for
// WAIT_CYCLES cycles. Address IO_ADDR can be decoded as an I/O port
// (reads return the switches, writes load the hex display register).
//
// Build option: define MEM_MMIO_EN to enable the I/O port. Without it
// IO_ADDR is an ordinary SRAM address, hex_out is 0 and S is ignored.
//
// Parameters: WAIT_CYCLES (1..15), IO_ADDR.
// Ports:
//   Clk, Reset          clock, synchronous active-low reset
//   bus                 request bus (slc3_mem_if.slave)
//   S                   switch inputs
//   hex_out             hex display register
//   CE, UB, LB, OE, WE  SRAM strobes, active-low, registered
//   ADDR                SRAM address, {4'b0, latched addr}
//   Data                SRAM data bus, driven only during writes
// -----------------------------------------------------------------------------
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    slc3_mem_if.slave              bus,
    input  logic [15:0]            S,
    output logic [15:0]            hex_out,
    output logic                   CE,
    output logic                   UB,
    output logic                   LB,
    output logic                   OE,
    output logic                   WE,
    output logic [SRAM_ADDR_W-1:0] ADDR,
    inout  wire  [15:0]            Data
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    mem_state_t   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  addr_q;
    logic [15:0]  wdata_q, wdata_d;
    logic         we_q;
    logic         accept;
    logic         io_hit;
    logic [15:0]  data_in;
    sram_strobe_t strobe_q;

    assign accept  = (state_q == IDLE) && bus.req;
    assign wdata_d = accept ? bus.wdata : wdata_q;

`ifdef MEM_MMIO_EN
    assign io_hit = (bus.addr == IO_ADDR);
`else
    assign io_hit = 1'b0;
    // The I/O port is not built; these inputs are intentionally ignored.
    logic unused_mmio;
    assign unused_mmio = ^{S, IO_ADDR, we_q};
`endif

    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cnt_d = WAIT_INIT;
                    if (io_hit)      state_d = IO;
                    else if (bus.we) state_d = WR_SETUP;
                    else             state_d = RD_STROBE;
                end
            end
            RD_STROBE: begin
                if (cnt_q == 4'd1) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = WAIT_INIT;
            end
            WR_STROBE: begin
                if (cnt_q == 4'd1) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: state_d = DONE;
            IO:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so strobes,
    // ready and busy change cleanly on the clock edge.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            strobe_q  <= STROBE_IDLE;
            bus.rdata <= 16'h0000;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
            strobe_q  <= strobes_for(state_d);
            bus.ready <= (state_d == DONE);
            bus.busy  <= (state_d != IDLE);
            if (accept) begin
                addr_q <= bus.addr;
                we_q   <= bus.we;
            end
            // Capture on the edge that ends the read strobe; the input path
            // is combinational, so this is the bus value under OE.
            if ((state_q == RD_STROBE) && (state_d == DONE))
                bus.rdata <= data_in;
`ifdef MEM_MMIO_EN
            if ((state_q == IO) && !we_q)
                bus.rdata <= S;
`endif
        end
    end

`ifdef MEM_MMIO_EN
    logic [15:0] hex_q;

    always_ff @(posedge Clk) begin
        if (!Reset)                   hex_q <= 16'h0000;
        else if ((state_q == IO) && we_q) hex_q <= wdata_q;
    end

    assign hex_out = hex_q;
`else
    assign hex_out = 16'h0000;
`endif

    assign CE   = strobe_q.ce;
    assign UB   = strobe_q.ub;
    assign LB   = strobe_q.lb;
    assign OE   = strobe_q.oe;
    assign WE   = strobe_q.we;
    assign ADDR = {4'b0000, addr_q};

    sram_tristate u_tristate (
        .Clk    (Clk),
        .Reset  (Reset),
        .oe_d   (drives_bus(state_d)),
        .dout_d (wdata_d),
        .din    (data_in),
        .Data   (Data)
    );

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slc3_mem_ctrl
// Self-checking bench for slc3_mem_ctrl with WAIT_CYCLES = 2. An SRAM model
// answers reads and records writes; a reference memory, expected rdata and
// expected hex register predict the results. Latency is counted with the
// accepting edge as edge 1. Works in both builds (MEM_MMIO_EN or not).
// -----------------------------------------------------------------------------
module tb_slc3_mem_ctrl;
    localparam int          W   = 2;
    localparam logic [15:0] IOA = 16'hFFFF;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] S     = 16'h0000;
    logic [15:0] hex_out;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    always #5 Clk = ~Clk;

    slc3_mem_if bus ();

    slc3_mem_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IOA)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .bus     (bus),
        .S       (S),
        .hex_out (hex_out),
        .CE      (CE),
        .UB      (UB),
        .LB      (LB),
        .OE      (OE),
        .WE      (WE),
        .ADDR    (ADDR),
        .Data    (Data)
    );

    // ---------------- SRAM model and activity monitor ----------------
    logic [15:0] sram [0:65535];
    assign Data = (!CE && !OE && WE) ? sram[ADDR[15:0]] : 16'hzzzz;

    int oe_low_n = 0, we_low_n = 0, ce_low_n = 0, drive_n = 0;
    int ready_n = 0, ready_long_n = 0, addr50_n = 0, bad_n = 0;
    logic ready_prev = 1'b0;

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'h5A5A;
        sram[16'h0040] = 16'h1234;
        forever begin
            @(posedge Clk);
            #1;
            if (!OE) oe_low_n++;
            if (!CE) ce_low_n++;
            if (!WE) begin
                we_low_n++;
                if (!CE) sram[ADDR[15:0]] = Data;
            end
            if (dut.u_tristate.oe_q) drive_n++;
            if (bus.ready) ready_n++;
            if (bus.ready && ready_prev) ready_long_n++;
            ready_prev = bus.ready;
            if (ADDR == 20'h00050) addr50_n++;
            if (ADDR[19:16] != 4'h0)               bad_n++;
            if (!CE && (UB || LB))                 bad_n++;
            if (CE && (!OE || !WE))                bad_n++;
            if (dut.u_tristate.oe_q && !OE)        bad_n++;
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] exp_hex   = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_io(input logic [15:0] a);
        bit hit;
        hit = 1'b0;
`ifdef MEM_MMIO_EN
        hit = (a == IOA);
`endif
        return hit;
    endfunction

    // One transaction. Starts on the negedge of an idle cycle (which is the
    // cycle right after the previous ready, so consecutive calls run
    // back-to-back) and returns on the negedge of the ready cycle.
    // inject: raise a second request (addr 0x0050) while the access is busy.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input bit inject);
        bit io;
        int lat, edges;
        int oe0, we0, ce0, dr0, rd0, a50;
        io  = is_io(a);
        lat = io ? 2 : (w ? W + 3 : W + 1);

        @(negedge Clk);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_ready", bus.ready, 1'b0);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        oe0 = oe_low_n; we0 = we_low_n; ce0 = ce_low_n;
        dr0 = drive_n;  rd0 = ready_n;  a50 = addr50_n;

        @(posedge Clk);
        edges = 1;
        @(negedge Clk);
        check("busy_rise", bus.busy, 1'b1);
        if (inject) begin
            bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0050;
        end else begin
            bus.req = 1'b0;
        end
        while (!bus.ready && edges < 40) begin
            @(posedge Clk);
            edges++;
            @(negedge Clk);
            bus.req = 1'b0;
        end
        check("latency", edges, lat);
        check("busy_in_done", bus.busy, 1'b1);

        if (w) begin
            if (io) exp_hex = d;
            else    ref_mem[a] = d;
        end else begin
            exp_rdata = io ? S : ref_mem[a];
        end
        check("rdata", bus.rdata, exp_rdata);
        check("hex_out", hex_out, exp_hex);
        check("sram_word", sram[a], ref_mem[a]);
        check("oe_cycles", oe_low_n - oe0, (io || w) ? 0 : W);
        check("we_cycles", we_low_n - we0, (!io && w) ? W : 0);
        check("ce_cycles", ce_low_n - ce0, io ? 0 : (w ? W + 2 : W));
        check("drive_cycles", drive_n - dr0, (!io && w) ? W + 2 : 0);
        check("ready_pulses", ready_n - rd0, 1);
        if (inject) check("addr_0050_seen", addr50_n - a50, 0);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] r;
        case ($urandom_range(0, 5))
            0:       r = 16'h0040;
            1:       r = 16'h0041;
            2:       r = IOA;
            3:       r = 16'hFFFE;
            4:       r = 16'h0100;
            default: r = 16'($urandom_range(0, 16'hFFFF));
        endcase
        if (r == 16'h0050) r = 16'h0051;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;
        ref_mem[16'h0040] = 16'h1234;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ce", CE, 1'b1);
        check("rst_oe_we", {OE, WE, UB, LB}, 4'hF);
        check("rst_addr", ADDR, 20'h0);
        check("rst_rdata", bus.rdata, 16'h0);
        check("rst_hex", hex_out, 16'h0);
        check("rst_ready_busy", {bus.ready, bus.busy}, 2'b00);
        check("rst_drive", dut.u_tristate.oe_q, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        // Directed: read, write, read-back, I/O port, busy rejection
        access(1'b0, 16'h0040, 16'h0000, 1'b0);
        access(1'b1, 16'h0041, 16'hBEEF, 1'b0);
        access(1'b0, 16'h0041, 16'h0000, 1'b0);
        S = 16'hA5A5;
        access(1'b0, IOA, 16'h0000, 1'b0);
        access(1'b1, IOA, 16'h00C3, 1'b0);
        access(1'b1, IOA, 16'h7777, 1'b0);
        access(1'b0, 16'h0040, 16'h0000, 1'b1);
        access(1'b0, 16'h0041, 16'h0000, 1'b0);

        // Reset in the middle of a write strobe
        @(negedge Clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0041; bus.wdata = 16'h5555;
        @(posedge Clk);
        @(negedge Clk);
        bus.req = 1'b0;
        k = 0;
        while (WE && k < 10) begin
            @(negedge Clk);
            k++;
        end
        check("reach_wr_strobe", WE, 1'b0);
        r0 = ready_n;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("mid_rst_we_ce", {WE, CE}, 2'b11);
        check("mid_rst_drive", dut.u_tristate.oe_q, 1'b0);
        check("mid_rst_busy_ready", {bus.busy, bus.ready}, 2'b00);
        check("mid_rst_rdata", bus.rdata, 16'h0);
        check("mid_rst_hex", hex_out, 16'h0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("mid_rst_no_ready", ready_n - r0, 0);
        // The strobe was low for at least one cycle, so the word was written.
        ref_mem[16'h0041] = 16'h5555;
        exp_rdata = 16'h0000;
        exp_hex   = 16'h0000;

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            S = 16'($urandom_range(0, 16'hFFFF));
            access(1'($urandom_range(0, 1)), pick_addr(),
                   16'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 3) == 0));
        end

        @(negedge Clk);
        check("ready_one_cycle", ready_long_n, 0);
        check("strobe_rules", bad_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
